// File: rtl/ula_8_bits_serial_resp.sv
// Valid/ready wrapper around the 74181-style ULA; computes the result SLICE_W bits per cycle.
// Define ULA_SINGLE_CYCLE_EN to compute the whole word in one CALC cycle instead.
module ula_8_bits_serial_resp #(
   parameter int WIDTH   = 8,
   parameter int SLICE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [3:0]       req_s,
   input  logic             req_m,
   input  logic             req_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_f,
   output logic             rsp_cout,
   output logic             rsp_ovf,
   output logic             rsp_eq
);

`ifdef ULA_SINGLE_CYCLE_EN
   localparam int PW = WIDTH;
`else
   localparam int PW = SLICE_W;
`endif
   localparam int NPASS = WIDTH / PW;
   localparam int IW = (NPASS > 1) ? $clog2(NPASS) : 1;
   // Functions where a set carry means "no borrow": report its inverse as carry-out.
   localparam logic [15:0] BORROW_MASK = 16'h08CD;

   typedef enum logic [1:0] {IDLE, CALC, RSP} state_t;

   function automatic logic [PW-1:0] logic_fn(input logic [3:0] s, input logic [PW-1:0] a,
                                              input logic [PW-1:0] b);
      logic [PW-1:0] r;
      case (s)
         4'h0: r = ~a;
         4'h1: r = ~(a | b);
         4'h2: r = ~a & b;
         4'h3: r = '0;
         4'h4: r = ~(a & b);
         4'h5: r = ~b;
         4'h6: r = a ^ b;
         4'h7: r = a & ~b;
         4'h8: r = a & b;
         4'h9: r = ~(a ^ b);
         4'hA: r = b;
         4'hB: r = ~a | b;
         4'hC: r = '1;
         4'hD: r = a | ~b;
         4'hE: r = a | b;
         default: r = a;
      endcase
      return r;
   endfunction

   function automatic logic [2*PW-1:0] arith_xy(input logic [3:0] s, input logic [PW-1:0] a,
                                                input logic [PW-1:0] b);
      logic [PW-1:0] x;
      logic [PW-1:0] y;
      case (s)
         4'h0: begin x = a;      y = '1;     end
         4'h1: begin x = a;      y = a | b;  end
         4'h2: begin x = a | b;  y = '1;     end
         4'h3: begin x = '0;     y = '1;     end
         4'h4: begin x = a;      y = a & b;  end
         4'h5: begin x = a | b;  y = a & b;  end
         4'h6: begin x = a;      y = ~b;     end
         4'h7: begin x = a & ~b; y = '1;     end
         4'h8: begin x = a;      y = a & ~b; end
         4'h9: begin x = a;      y = b;      end
         4'hA: begin x = a | ~b; y = a & b;  end
         4'hB: begin x = a & b;  y = '1;     end
         4'hC: begin x = a;      y = a;      end
         4'hD: begin x = a | b;  y = a;      end
         4'hE: begin x = a | ~b; y = a;      end
         default: begin x = a;   y = '0;     end
      endcase
      return {x, y};
   endfunction

   state_t           state_q, state_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [3:0]       s_q, s_d;
   logic             m_q, m_d, cin_q, cin_d;
   logic [WIDTH-1:0] f_q, f_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, eq_q, eq_d;

   logic [IW-1:0]    idx;
   logic             cin_slice;
   logic             last;
   logic [PW-1:0]    a_sl, b_sl, x_sl, y_sl, res;
   logic [PW:0]      sum;
   logic             c_msb;

`ifdef ULA_SINGLE_CYCLE_EN
   assign idx       = '0;
   assign cin_slice = cin_q;
   assign last      = 1'b1;
`else
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;

   assign idx       = idx_q;
   assign cin_slice = (idx_q == '0) ? cin_q : carry_q;
   assign last      = (int'(idx_q) == NPASS - 1);
`endif

   assign a_sl = a_q[int'(idx)*PW +: PW];
   assign b_sl = b_q[int'(idx)*PW +: PW];

   // Slice datapath plus next-state/output logic for the request/response FSM.
   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      a_d         = a_q;
      b_d         = b_q;
      s_d         = s_q;
      m_d         = m_q;
      cin_d       = cin_q;
      f_d         = f_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      eq_d        = eq_q;
`ifndef ULA_SINGLE_CYCLE_EN
      idx_d       = idx_q;
      carry_d     = carry_q;
`endif
      {x_sl, y_sl} = arith_xy(s_q, a_sl, b_sl);
      sum   = {1'b0, x_sl} + {1'b0, y_sl} + {{PW{1'b0}}, cin_slice};
      c_msb = x_sl[PW-1] ^ y_sl[PW-1] ^ sum[PW-1];
      res   = m_q ? logic_fn(s_q, a_sl, b_sl) : sum[PW-1:0];

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               a_d         = req_a;
               b_d         = req_b;
               s_d         = req_s;
               m_d         = req_m;
               cin_d       = req_cin;
               req_ready_d = 1'b0;
               state_d     = CALC;
`ifndef ULA_SINGLE_CYCLE_EN
               idx_d       = '0;
               carry_d     = 1'b0;
`endif
            end
         end
         CALC: begin
            f_d[int'(idx)*PW +: PW] = res;
`ifndef ULA_SINGLE_CYCLE_EN
            carry_d = sum[PW];
            idx_d   = idx_q + 1'b1;
`endif
            if (last) begin
               cout_d      = m_q ? 1'b0 : (BORROW_MASK[s_q] ? ~sum[PW] : sum[PW]);
               ovf_d       = m_q ? 1'b0 : (c_msb ^ sum[PW]);
               eq_d        = &f_d;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         m_q         <= 1'b0;
         cin_q       <= 1'b0;
         f_q         <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         eq_q        <= 1'b0;
`ifndef ULA_SINGLE_CYCLE_EN
         idx_q       <= '0;
         carry_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         s_q         <= s_d;
         m_q         <= m_d;
         cin_q       <= cin_d;
         f_q         <= f_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         eq_q        <= eq_d;
`ifndef ULA_SINGLE_CYCLE_EN
         idx_q       <= idx_d;
         carry_q     <= carry_d;
`endif
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_f     = f_q;
   assign rsp_cout  = cout_q;
   assign rsp_ovf   = ovf_q;
   assign rsp_eq    = eq_q;

endmodule

// File: tb/tb_ula_8_bits_serial_resp.sv
// Randomized self-checking bench for ula_8_bits_serial_resp against a full-width reference model.
module tb_ula_8_bits_serial_resp;

`ifdef ULA_SINGLE_CYCLE_EN
   localparam int EXP_LAT = 1;
`else
   localparam int EXP_LAT = 2;
`endif

   logic       clk, rst;
   logic       req_valid, req_ready;
   logic [7:0] req_a, req_b;
   logic [3:0] req_s;
   logic       req_m, req_cin;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_f;
   logic       rsp_cout, rsp_ovf, rsp_eq;

   int vectors = 0;
   int miscompares = 0;

   ula_8_bits_serial_resp #(.WIDTH(8), .SLICE_W(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_cin(req_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_eq(rsp_eq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: whole-word 74181 behaviour returning {f, cout, ovf, eq}.
   function automatic logic [10:0] refModel(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] s, input logic m, input logic cin);
      logic [7:0] x, y, f;
      int sum, lowSum;
      logic c, cout, ovf;
      x = 8'h00; y = 8'h00; f = 8'h00; cout = 1'b0; ovf = 1'b0;
      if (m) begin
         case (s)
            4'h0: f = ~a;         4'h1: f = ~(a | b);  4'h2: f = ~a & b;    4'h3: f = 8'h00;
            4'h4: f = ~(a & b);   4'h5: f = ~b;        4'h6: f = a ^ b;     4'h7: f = a & ~b;
            4'h8: f = a & b;      4'h9: f = ~(a ^ b);  4'hA: f = b;         4'hB: f = ~a | b;
            4'hC: f = 8'hFF;      4'hD: f = a | ~b;    4'hE: f = a | b;     default: f = a;
         endcase
      end else begin
         case (s)
            4'h0: begin x = a;      y = 8'hFF;  end
            4'h1: begin x = a;      y = a | b;  end
            4'h2: begin x = a | b;  y = 8'hFF;  end
            4'h3: begin x = 8'h00;  y = 8'hFF;  end
            4'h4: begin x = a;      y = a & b;  end
            4'h5: begin x = a | b;  y = a & b;  end
            4'h6: begin x = a;      y = ~b;     end
            4'h7: begin x = a & ~b; y = 8'hFF;  end
            4'h8: begin x = a;      y = a & ~b; end
            4'h9: begin x = a;      y = b;      end
            4'hA: begin x = a | ~b; y = a & b;  end
            4'hB: begin x = a & b;  y = 8'hFF;  end
            4'hC: begin x = a;      y = a;      end
            4'hD: begin x = a | b;  y = a;      end
            4'hE: begin x = a | ~b; y = a;      end
            default: begin x = a;   y = 8'h00;  end
         endcase
         sum    = int'(x) + int'(y) + int'(cin);
         lowSum = int'(x[6:0]) + int'(y[6:0]) + int'(cin);
         f      = sum[7:0];
         c      = sum[8];
         ovf    = c ^ lowSum[7];
         cout   = (s inside {4'h0, 4'h2, 4'h3, 4'h6, 4'h7, 4'hB}) ? ~c : c;
      end
      return {f, cout, ovf, &f};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   // Issue one request, check latency and result, stall the response holdCycles cycles.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                                input logic m, input logic cin, input int holdCycles);
      logic [10:0] exp;
      logic [10:0] held;
      int lat;
      exp = refModel(a, b, s, m, cin);
      @(negedge clk);
      req_a = a; req_b = b; req_s = s; req_m = m; req_cin = cin; req_valid = 1'b1;
      checkOutput("req_ready_before", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 10) begin
         @(posedge clk);
         #1 lat++;
      end
      checkOutput("latency", 32'(lat), 32'(EXP_LAT));
      checkOutput($sformatf("f_m%0d_s%0h", m, s), 32'(rsp_f), 32'(exp[10:3]));
      checkOutput($sformatf("cout_m%0d_s%0h", m, s), 32'(rsp_cout), 32'(exp[2]));
      checkOutput($sformatf("ovf_m%0d_s%0h", m, s), 32'(rsp_ovf), 32'(exp[1]));
      checkOutput($sformatf("eq_m%0d_s%0h", m, s), 32'(rsp_eq), 32'(exp[0]));
      held = exp;
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_a = 8'($urandom);
         req_b = 8'($urandom);
         @(posedge clk);
         #1;
         checkOutput("hold_outputs", 32'({rsp_f, rsp_cout, rsp_ovf, rsp_eq}), 32'(held));
         checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
         checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      checkIdleOutputs("after_handshake");
   endtask

   initial begin
      rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_a = 8'h00; req_b = 8'h00; req_s = 4'h0; req_m = 1'b0; req_cin = 1'b0;
      #2 rst = 1'b1;
      #10;
      checkIdleOutputs("reset");
      checkOutput("reset_flags", 32'({rsp_f, rsp_cout, rsp_ovf, rsp_eq}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases: MSB overflow, carry across slices, borrow-style, logic all-ones.
      applyStimulus(8'h7F, 8'h01, 4'h9, 1'b0, 1'b0, 0);
      applyStimulus(8'hFF, 8'h01, 4'h9, 1'b0, 1'b0, 0);
      applyStimulus(8'h50, 8'h21, 4'h6, 1'b0, 1'b1, 0);
      applyStimulus(8'h10, 8'h00, 4'h0, 1'b0, 1'b0, 0);
      applyStimulus(8'hAA, 8'h55, 4'h6, 1'b1, 1'b0, 5);

      // Reset while in CALC drops the operation.
      @(negedge clk);
      req_a = 8'h7F; req_b = 8'h01; req_s = 4'h9; req_m = 1'b0; req_cin = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkIdleOutputs("midcalc_reset");
      checkOutput("midcalc_reset_f", 32'(rsp_f), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1 checkOutput("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
      end
      applyStimulus(8'h3C, 8'h0F, 4'h9, 1'b0, 1'b1, 1);

      // Sweep every function in both modes with random operands.
      for (int m = 0; m < 2; m++)
         for (int s = 0; s < 16; s++)
            applyStimulus(8'($urandom), 8'($urandom), 4'(s), 1'(m), 1'($urandom_range(1)), 0);

      for (int n = 0; n < 60; n++)
         applyStimulus(8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom_range(1)),
                       1'($urandom_range(1)), int'($urandom_range(2)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
